// File: rtl/mem_port_arbiter.sv
// Three-way round-robin arbiter for a shared single-port memory.
// Debug port can lock the memory or halt the CPU ports.
module mem_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                ins_req_i,
  input  logic [ADDRSIZE-1:0] ins_addr_i,
  output logic                ins_gnt_o,
  output logic                ins_rvalid_o,
  input  logic                dat_req_i,
  input  logic                dat_we_i,
  input  logic [ADDRSIZE-1:0] dat_addr_i,
  input  logic [WIDTH-1:0]    dat_wdata_i,
  output logic                dat_gnt_o,
  output logic                dat_rvalid_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [ADDRSIZE-1:0] dbg_addr_i,
  input  logic [WIDTH-1:0]    dbg_wdata_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  input  logic                dbg_lock_i,
  input  logic                dbg_halt_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic [ADDRSIZE-1:0] mem_addr_o,
  output logic                mem_we_o,
  output logic                mem_en_o,
  output logic [WIDTH-1:0]    mem_wdata_o,
  input  logic [WIDTH-1:0]    mem_rdata_i
);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  localparam logic [1:0] P_INS = 2'd0;
  localparam logic [1:0] P_DAT = 2'd1;
  localparam logic [1:0] P_DBG = 2'd2;

  state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] req, gnt;

  logic [ADDRSIZE-1:0] mem_addr_q;
  logic [WIDTH-1:0]    mem_wdata_q;
  logic                mem_en_q, mem_we_q;

  logic [ADDRSIZE-1:0] sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic                sel_we;
  logic [1:0]          sel_id;

  logic       t1_v_q, t2_v_q;
  logic [1:0] t1_id_q, t2_id_q;

  assign req = {dbg_req_i,
                dat_req_i & ~dbg_halt_i,
                ins_req_i & ~dbg_halt_i};

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= UNLOCKED;
      ptr_q   <= P_DAT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (gnt[2] && dbg_lock_i) state_d = LOCKED;
      LOCKED:   if (!dbg_lock_i) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // Locked with lock still high: only dbg may win.
  always_comb begin
    gnt = 3'b000;
    if (!rst_i) begin
      if (state_q == LOCKED && dbg_lock_i) begin
        gnt = {req[2], 2'b00};
      end else begin
        case (ptr_q)
          P_INS: begin
            if (req[0])      gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
          end
          P_DAT: begin
            if (req[1])      gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
          end
          default: begin
            if (req[2])      gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
          end
        endcase
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) ptr_d = P_DAT;
    if (gnt[1]) ptr_d = P_DBG;
    if (gnt[2]) ptr_d = P_INS;
  end

  always_comb begin
    sel_addr  = ins_addr_i;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_id    = P_INS;
    if (gnt[1]) begin
      sel_addr  = dat_addr_i;
      sel_wdata = dat_wdata_i;
      sel_we    = dat_we_i;
      sel_id    = P_DAT;
    end else if (gnt[2]) begin
      sel_addr  = dbg_addr_i;
      sel_wdata = dbg_wdata_i;
      sel_we    = dbg_we_i;
      sel_id    = P_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      t1_v_q      <= 1'b0;
      t1_id_q     <= '0;
      t2_v_q      <= 1'b0;
      t2_id_q     <= '0;
    end else begin
      mem_en_q <= |gnt;
      mem_we_q <= |gnt & sel_we;
      if (|gnt) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      t1_v_q  <= |gnt & ~sel_we;
      t1_id_q <= sel_id;
      t2_v_q  <= t1_v_q;
      t2_id_q <= t1_id_q;
    end
  end

  assign ins_gnt_o    = gnt[0];
  assign dat_gnt_o    = gnt[1];
  assign dbg_gnt_o    = gnt[2];
  assign ins_rvalid_o = t2_v_q && (t2_id_q == P_INS);
  assign dat_rvalid_o = t2_v_q && (t2_id_q == P_DAT);
  assign dbg_rvalid_o = t2_v_q && (t2_id_q == P_DBG);
  assign rdata_o      = mem_rdata_i;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_en_o     = mem_en_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural
// single-port memory attached to the mem_* port.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic ins_req, dat_req, dat_we, dbg_req, dbg_we;
  logic dbg_lock, dbg_halt;
  logic [11:0] ins_addr, dat_addr, dbg_addr;
  logic [31:0] dat_wdata, dbg_wdata;
  logic ins_gnt, dat_gnt, dbg_gnt;
  logic ins_rvalid, dat_rvalid, dbg_rvalid;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  logic mem_we, mem_en;

  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:4095];

  int total = 0;
  int bad = 0;

  wire [2:0] g  = {dbg_gnt, dat_gnt, ins_gnt};
  wire [2:0] rv = {dbg_rvalid, dat_rvalid, ins_rvalid};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12)) dut (
    .clk(clk), .rst_i(rst),
    .ins_req_i(ins_req), .ins_addr_i(ins_addr),
    .ins_gnt_o(ins_gnt), .ins_rvalid_o(ins_rvalid),
    .dat_req_i(dat_req), .dat_we_i(dat_we),
    .dat_addr_i(dat_addr), .dat_wdata_i(dat_wdata),
    .dat_gnt_o(dat_gnt), .dat_rvalid_o(dat_rvalid),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
    .dbg_lock_i(dbg_lock), .dbg_halt_i(dbg_halt),
    .rdata_o(rdata), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_en_o(mem_en),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ins_req = 0; dat_req = 0; dbg_req = 0;
    dat_we = 0; dbg_we = 0;
    dbg_lock = 0; dbg_halt = 0;
    ins_addr = '0; dat_addr = '0; dbg_addr = '0;
    dat_wdata = '0; dbg_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    ins_req = 1; dat_req = 1; dbg_req = 1;
    tick();
    tick();
    total++;
    if (g !== 3'b000) begin
      bad++; $display("FAIL rst_gnt got=%b exp=000", g);
    end
    total++;
    if ({mem_en, mem_we} !== 2'b00) begin
      bad++; $display("FAIL rst_en_we got=%b exp=00", {mem_en, mem_we});
    end
    total++;
    if (mem_addr !== 12'h000 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    total++;
    if (rv !== 3'b000) begin
      bad++; $display("FAIL rst_rvalid got=%b exp=000", rv);
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_ins_read();
    apply_reset();
    ins_req = 1; ins_addr = 12'h005;
    #1;
    total++;
    if (g !== 3'b001) begin
      bad++; $display("FAIL ins_gnt got=%b exp=001", g);
    end
    tick();
    ins_req = 0;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h005) begin
      bad++; $display("FAIL ins_memport got=%b%b/%h exp=10/005", mem_en, mem_we, mem_addr);
    end
    total++;
    if (rv !== 3'b000) begin
      bad++; $display("FAIL ins_rv_early got=%b exp=000", rv);
    end
    tick();
    total++;
    if (rv !== 3'b001 || rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ins_rvalid got=%b/%h exp=001/deadbeef", rv, rdata);
    end
    tick();
    total++;
    if (rv !== 3'b000 || mem_en !== 1'b0) begin
      bad++; $display("FAIL ins_after got=%b/%b exp=000/0", rv, mem_en);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [6];
    logic [11:0] exp_a [6];
    exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{12'h200, 12'h300, 12'h100, 12'h200, 12'h300, 12'h100};
    apply_reset();
    ins_req = 1; ins_addr = 12'h100;
    dat_req = 1; dat_addr = 12'h200;
    dbg_req = 1; dbg_addr = 12'h300;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (g !== exp_g[i]) begin
        bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, g, exp_g[i]);
      end
      tick();
      total++;
      if (mem_en !== 1'b1 || mem_addr !== exp_a[i]) begin
        bad++; $display("FAIL rr_mem%0d got=%b/%h exp=1/%h", i, mem_en, mem_addr, exp_a[i]);
      end
      if (i > 0) begin
        total++;
        if (rv !== exp_g[i-1]) begin
          bad++; $display("FAIL rr_rv%0d got=%b exp=%b", i, rv, exp_g[i-1]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    apply_reset();
    dat_req = 1; dat_we = 1;
    dat_addr = 12'h010; dat_wdata = 32'h00000123;
    #1;
    total++;
    if (g !== 3'b010) begin
      bad++; $display("FAIL wr_gnt got=%b exp=010", g);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'h123) begin
      bad++; $display("FAIL wr_mem got=%b%b/%h/%h exp=11/010/00000123", mem_en, mem_we, mem_addr, mem_wdata);
    end
    dat_we = 0;
    #1;
    total++;
    if (g !== 3'b010) begin
      bad++; $display("FAIL rd_gnt got=%b exp=010", g);
    end
    tick();
    dat_req = 0;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || rv !== 3'b000) begin
      bad++; $display("FAIL rd_mem got=%b%b rv=%b exp=10 rv=000", mem_en, mem_we, rv);
    end
    tick();
    total++;
    if (rv !== 3'b010 || rdata !== 32'h00000123) begin
      bad++; $display("FAIL rd_data got=%b/%h exp=010/00000123", rv, rdata);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    dbg_req = 1; dbg_we = 1; dbg_lock = 1;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 12'h020 + 12'(i);
      dbg_wdata = 32'hA000 + 32'(i);
      #1;
      total++;
      if (g !== 3'b100) begin
        bad++; $display("FAIL lock_gnt%0d got=%b exp=100", i, g);
      end
      tick();
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 12'h020 + 12'(i) || mem_wdata !== 32'hA000 + 32'(i)) begin
        bad++; $display("FAIL lock_mem%0d got=%b/%h/%h", i, mem_we, mem_addr, mem_wdata);
      end
      ins_req = 1; ins_addr = 12'h111;
      dat_req = 1; dat_addr = 12'h222;
    end
    dbg_lock = 0;
    #1;
    total++;
    if (g !== 3'b001) begin
      bad++; $display("FAIL unlock_gnt got=%b exp=001", g);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_halt();
    apply_reset();
    dbg_halt = 1;
    ins_req = 1; dat_req = 1; dbg_req = 1;
    #1;
    total++;
    if (g !== 3'b100) begin
      bad++; $display("FAIL halt_dbg got=%b exp=100", g);
    end
    tick();
    dbg_req = 0;
    #1;
    total++;
    if (g !== 3'b000) begin
      bad++; $display("FAIL halt_none got=%b exp=000", g);
    end
    tick();
    total++;
    if (mem_en !== 1'b0) begin
      bad++; $display("FAIL halt_en got=%b exp=0", mem_en);
    end
    dbg_halt = 0;
    #1;
    total++;
    if (g !== 3'b001) begin
      bad++; $display("FAIL unhalt_ins got=%b exp=001", g);
    end
    tick();
    #1;
    total++;
    if (g !== 3'b010) begin
      bad++; $display("FAIL unhalt_dat got=%b exp=010", g);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ins_req = 1; ins_addr = 12'h007;
    dat_req = 1; dat_addr = 12'h008;
    tick();
    ins_req = 1; dat_req = 0;
    tick();
    ins_req = 0;
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (rv !== 3'b000) begin
      bad++; $display("FAIL rstmid_rv got=%b exp=000", rv);
    end
    total++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL rstmid_mem got=%b%b/%h/%h exp=00/0/0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    total++;
    if (rv !== 3'b000) begin
      bad++; $display("FAIL rstmid_rv2 got=%b exp=000", rv);
    end
    ins_req = 1; dat_req = 1; dbg_req = 1;
    #1;
    total++;
    if (g !== 3'b010) begin
      bad++; $display("FAIL rstmid_ptr got=%b exp=010", g);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    pl_en = 1; pl_addr = 12'h005; pl_data = 32'hDEADBEEF;
    tick();
    pl_en = 0;
    test_reset();
    test_ins_read();
    test_round_robin();
    test_write_read();
    test_lock();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous 4096x32 memory among three requesters: CPU instruction fetch, CPU data load/store, and an external debug/loader port. Grants at most one access per cycle, round-robin with a debug lock and halt, registers the command onto the memory port, and routes read data back to the requester that issued it. Sits between the instruction-set core's instruction/data buses and the shared memory.

## Interface
- WIDTH, 32, data width
- ADDRSIZE, 12, address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ins_req  in  1  instruction-fetch request (read only)
- ins_addr  in  ADDRSIZE  fetch address
- ins_gnt  out  1  fetch request accepted this cycle
- ins_rvalid  out  1  fetch data valid on rdata
- dat_req  in  1  data request
- dat_we  in  1  0 read, 1 write
- dat_addr  in  ADDRSIZE  data address
- dat_wdata  in  WIDTH  write data
- dat_gnt, dat_rvalid  out  1 each  as for ins
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid  as for dat
- dbg_lock  in  1  while set and dbg granted, keep dbg exclusive
- dbg_halt  in  1  mask ins_req and dat_req
- rdata  out  WIDTH  read data (shared, qualified by *_rvalid)
- mem_addr  out  ADDRSIZE  registered memory address
- mem_we  out  1  registered write strobe
- mem_en  out  1  registered access enable
- mem_wdata  out  WIDTH  registered write data
- mem_rdata  in  WIDTH  memory read data, one cycle after mem_en

## Operation
- Requester holds req/addr/we/wdata stable until gnt seen high at a rising edge; transfer occurs on the edge where req && gnt.
- gnt is combinational from current req, masks and priority pointer; at most one gnt high per cycle; gnt never high without its req.
- Effective requests: ins_req & ~dbg_halt, dat_req & ~dbg_halt, dbg_req.
- Round-robin order ins -> dat -> dbg -> ins. Pointer names highest-priority port; after a grant, pointer moves to the port following the granted one. No grant: pointer unchanged. Reset pointer = dat.
- Lock: if dbg granted on edge N and dbg_lock high at N, state LOCKED; in LOCKED only dbg may be granted. Leave LOCKED on the first edge with dbg_lock low (grant in that cycle follows normal round-robin with pointer at ins). dbg_halt independent of lock.
- On grant edge: mem_addr/mem_we/mem_wdata load from granted port, mem_en=1. No grant: mem_en=0, mem_we=0, addr/wdata hold.
- Reads: 2-stage tag pipeline (port id + read flag). Grant at edge N -> mem_en in cycle N..N+1 -> matching *_rvalid high for exactly the cycle after edge N+1, rdata = mem_rdata passthrough. Writes produce no rvalid.
- Back-to-back grants every cycle allowed; rvalids never overlap since one access issues per cycle.

## Timing
- Reset (rst high at edge): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all rvalid=0, tags cleared, pointer=dat, state UNLOCKED. All gnt forced 0 while rst high.
- Reset mid-operation: in-flight reads dropped, no rvalid after reset edge.
- Throughput 1 access/cycle; read latency 2 edges from grant edge to rvalid cycle.
- Worst-case wait with all three requesting, no lock/halt: 2 cycles.
- Simultaneous dbg_halt rise with pending ins/dat: masked that same cycle; already-issued reads still return.

## Test plan
- Reset then ins_req only, addr 0x005, mem returns 0xDEADBEEF -> ins_gnt same cycle, mem_en/mem_addr=0x005 next cycle, ins_rvalid with rdata=0xDEADBEEF two edges after grant.
- All three req held continuously from reset -> grants dat, dbg, ins, dat, dbg, ins; one mem_en per cycle.
- dat write 0x00000123 to 0x010, then dat read 0x010 -> mem_we=1 first, then read returns 0x123 with dat_rvalid only.
- dbg_lock=1, dbg 4 back-to-back writes while ins/dat requesting -> only dbg_gnt for 4 cycles; lock drop -> next grant ins.
- dbg_halt=1 with ins/dat req high -> no ins_gnt/dat_gnt; dbg still granted; halt released -> round-robin resumes.
- rst asserted one cycle after an ins read grant -> no ins_rvalid, all mem_* at reset values, pointer=dat.
